// File: rtl/interface_hcsr04_uc.sv
// Control unit for the HC-SR04 ultrasonic sensor: fires the trigger pulse, waits for the echo,
// lets the downstream contador_cm count it and latches the BCD result (or aborts on timeout).
module interface_hcsr04_uc #(
  parameter int TRIG_CICLOS    = 500,
  parameter int TIMEOUT_CICLOS = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  input  logic        pronto_cm,
  input  logic [11:0] digitos_cm,
  output logic        trigger,
  output logic        pulso_cm,
  output logic        zera_cm,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  localparam int TRIG_W = (TRIG_CICLOS > 1) ? $clog2(TRIG_CICLOS) : 1;
  localparam int TO_W   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CICLOS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_ECHO   = 4'd3,
    ST_MEDE          = 4'd4,
    ST_ARMAZENA      = 4'd5,
    ST_FINAL         = 4'd6,
    ST_ERRO          = 4'd7
  } estado_t;

  estado_t           estado_q, estado_d;
  logic              echo_s1_q, echo_s2_q;
  logic              medir_q;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [11:0]       medida_q, medida_d;
  logic              start;
  logic [TO_W-1:0]   to_cnt_inc;

  assign start = medir & ~medir_q;
  // Saturates at the last count so the counter fits its $clog2 width even if mede is
  // entered on the very cycle the limit is reached.
  assign to_cnt_inc = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_INICIAL;
      echo_s1_q  <= 1'b0;
      echo_s2_q  <= 1'b0;
      medir_q    <= 1'b0;
      trig_cnt_q <= '0;
      to_cnt_q   <= '0;
      medida_q   <= 12'h000;
    end else begin
      estado_q   <= estado_d;
      echo_s1_q  <= echo;
      echo_s2_q  <= echo_s1_q;
      medir_q    <= medir;
      trig_cnt_q <= trig_cnt_d;
      to_cnt_q   <= to_cnt_d;
      medida_q   <= medida_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    trig_cnt_d = trig_cnt_q;
    to_cnt_d   = to_cnt_q;
    medida_d   = medida_q;
    case (estado_q)
      ST_INICIAL: begin
        if (start) estado_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        trig_cnt_d = '0;
        estado_d   = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        if (trig_cnt_q == TRIG_LAST) begin
          to_cnt_d = '0;
          estado_d = ST_ESPERA_ECHO;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      // In both wait states the exit condition takes priority over the timeout.
      ST_ESPERA_ECHO: begin
        to_cnt_d = to_cnt_inc;
        if (echo_s2_q)                estado_d = ST_MEDE;
        else if (to_cnt_q == TO_LAST) estado_d = ST_ERRO;
      end
      ST_MEDE: begin
        to_cnt_d = to_cnt_inc;
        if (pronto_cm)                estado_d = ST_ARMAZENA;
        else if (to_cnt_q == TO_LAST) estado_d = ST_ERRO;
      end
      ST_ARMAZENA: begin
        medida_d = digitos_cm;
        estado_d = ST_FINAL;
      end
      ST_FINAL: estado_d = ST_INICIAL;
      ST_ERRO:  estado_d = ST_INICIAL;
      default:  estado_d = ST_INICIAL;
    endcase
  end

  assign trigger   = (estado_q == ST_ENVIA_TRIGGER);
  assign zera_cm   = (estado_q == ST_PREPARACAO);
  assign pronto    = (estado_q == ST_FINAL);
  assign timeout   = (estado_q == ST_ERRO);
  assign pulso_cm  = echo_s2_q;
  assign medida    = medida_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Bench for interface_hcsr04_uc: a per-measurement timeline model fills expected output
// waveforms, a compare process checks them every cycle, then an async-reset abort is exercised.
module tb_interface_hcsr04_uc;

  localparam int T  = 5;
  localparam int TO = 100;
  localparam int N  = 8192;

  logic        clock = 1'b0;
  logic        reset, medir, echo, pronto_cm;
  logic [11:0] digitos_cm;
  logic        trigger, pulso_cm, zera_cm, pronto, timeout;
  logic [11:0] medida;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  interface_hcsr04_uc #(.TRIG_CICLOS(T), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo), .pronto_cm(pronto_cm),
    .digitos_cm(digitos_cm), .trigger(trigger), .pulso_cm(pulso_cm), .zera_cm(zera_cm),
    .medida(medida), .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
  );

  // stimulus per clock edge index, and the outputs expected just after that edge
  bit          in_medir[N], in_echo[N], in_pcm[N];
  bit   [11:0] in_dig[N];
  bit          ex_trig[N], ex_zera[N], ex_pronto[N], ex_tout[N], ex_pulso[N];
  bit   [3:0]  ex_est[N];
  bit   [11:0] ex_med[N];

  logic [11:0] exp_q[$];
  int dut_rise_q[$], dut_fall_q[$], dut_zera_q[$], dut_pronto_q[$], dut_tout_q[$];
  int checks, errors, edge_idx, cursor, n_meas, run_len, n_tout_model;
  bit chk_en, trig_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_idx);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  // One measurement: medir rises gap edges after cursor; echo rises ed edges after the trigger
  // falls (ed<0: never); pronto_cm pulses pcm_at edges after the fall (pcm_at<0: never).
  task automatic add_meas(input int gap, input int hold, input int ed, input int ew,
                          input int pcm_at, input logic [11:0] dig, input bit glitch,
                          input bit noisy);
    int s, f, m, a, terr, e, lim, last_hi, stop;
    s = cursor + gap;
    f = s + T + 1;
    for (int i = 0; i < hold; i++) in_medir[s + i] = 1'b1;
    last_hi = s + hold - 1;
    for (int i = cursor; i <= f + TO + 2; i++) in_dig[i] = noisy ? 12'($urandom) : dig;
    if (ed >= 0) for (int i = 0; i < ew; i++) in_echo[f + ed + i] = 1'b1;
    in_pcm[s + 2] = 1'b1;
    in_pcm[f + 1] = 1'b1;
    if (pcm_at > 0) in_pcm[f + pcm_at] = 1'b1;
    m = -1; a = -1; terr = -1;
    for (int n = f + 1; n <= f + TO; n++) if (m < 0 && in_echo[n - 2]) m = n;
    if (m < 0) terr = f + TO;
    else begin
      lim = (m + 1 > f + TO) ? m + 1 : f + TO;
      for (int n = m + 1; n <= lim; n++) if (a < 0 && in_pcm[n]) a = n;
      if (a < 0) terr = lim;
    end
    ex_zera[s] = 1'b1;
    ex_est[s]  = 4'd1;
    for (int n = s + 1; n <= s + T; n++) begin ex_trig[n] = 1'b1; ex_est[n] = 4'd2; end
    stop = (m >= 0) ? m : terr;
    for (int n = f; n < stop; n++) ex_est[n] = 4'd3;
    if (m >= 0) begin
      stop = (a >= 0) ? a : terr;
      for (int n = m; n < stop; n++) ex_est[n] = 4'd4;
    end
    if (a >= 0) begin
      ex_est[a] = 4'd5; ex_est[a + 1] = 4'd6; ex_pronto[a + 1] = 1'b1;
      in_dig[a + 1] = dig;
      exp_q.push_back(dig);
      e = a + 2;
    end else begin
      ex_est[terr] = 4'd7; ex_tout[terr] = 1'b1;
      n_tout_model++;
      e = terr + 1;
    end
    for (int n = e; n <= f + TO + 200; n++) in_echo[n] = 1'b0;
    if (glitch && s + hold + 3 <= e) begin
      in_medir[s + hold + 2] = 1'b1; in_medir[s + hold + 3] = 1'b1;
      last_hi = s + hold + 3;
    end
    cursor = (e + 1 > last_hi + 1) ? e + 1 : last_hi + 1;
    n_meas++;
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      check("trigger",   trigger,   ex_trig[edge_idx]);
      check("zera_cm",   zera_cm,   ex_zera[edge_idx]);
      check("pronto",    pronto,    ex_pronto[edge_idx]);
      check("timeout",   timeout,   ex_tout[edge_idx]);
      check("pulso_cm",  pulso_cm,  ex_pulso[edge_idx]);
      check("medida",    medida,    ex_med[edge_idx]);
      check("db_estado", db_estado, ex_est[edge_idx]);
      if (trigger && !trig_prev) dut_rise_q.push_back(edge_idx);
      if (!trigger && trig_prev) dut_fall_q.push_back(edge_idx);
      trig_prev = trigger;
      if (zera_cm) dut_zera_q.push_back(edge_idx);
      if (timeout) dut_tout_q.push_back(edge_idx);
      if (pronto) begin
        dut_pronto_q.push_back(edge_idx);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pronto_unexpected: got pronto=1 expected no pending result (edge %0d)", edge_idx);
        end else check("medida_on_pronto", medida, exp_q.pop_front());
      end
    end
  end

  initial begin
    int run, strobes;
    bit seen;
    checks = 0; errors = 0; chk_en = 1'b0; edge_idx = 0; trig_prev = 1'b0;
    n_meas = 0; n_tout_model = 0;
    reset = 1'b0; medir = 1'b0; echo = 1'b0; pronto_cm = 1'b0; digitos_cm = 12'h000;

    cursor = 1;
    add_meas(2, 3,   20,  30,  32, 12'h123, 1'b0, 1'b0);
    add_meas(3, 2,   -1,   0,  -1, 12'h0AB, 1'b0, 1'b0);
    add_meas(2, 4,   10, 200,  -1, 12'h0CD, 1'b0, 1'b0);
    add_meas(2, 3,   20,  30,  32, 12'h045, 1'b0, 1'b0);
    add_meas(2, 3,   10,  40, 100, 12'h321, 1'b0, 1'b0);
    add_meas(2, 500, 15,  10,  40, 12'h777, 1'b0, 1'b0);
    for (int k = 0; k < 25 && cursor < N - 1200; k++) begin
      int ed, pa;
      ed = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 105));
      if (ed < 0 || $urandom_range(0, 5) == 0) pa = $urandom_range(1, 101);
      else pa = ed + int'($urandom_range(3, 30));
      if (pa > 101) pa = -1;
      add_meas($urandom_range(1, 8), $urandom_range(1, 30), ed, $urandom_range(1, 60), pa,
               12'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    run_len = cursor + 5;
    run = 0;
    for (int n = 0; n < run_len; n++) begin
      if (ex_pronto[n]) run = in_dig[n];
      ex_med[n]   = 12'(run);
      ex_pulso[n] = (n == 0) ? 1'b0 : in_echo[n - 1];
    end

    #2 reset = 1'b1;
    echo = 1'b1; medir = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_trigger", trigger, 0);   check("rst_zera", zera_cm, 0);
    check("rst_pronto", pronto, 0);     check("rst_timeout", timeout, 0);
    check("rst_pulso", pulso_cm, 0);    check("rst_medida", medida, 12'h000);
    check("rst_estado", db_estado, 0);
    echo = 1'b0; medir = 1'b0;
    @(negedge clock) reset = 1'b0;

    for (int n = 0; n < run_len; n++) begin
      @(negedge clock);
      medir = in_medir[n]; echo = in_echo[n]; pronto_cm = in_pcm[n]; digitos_cm = in_dig[n];
      edge_idx = n;
      chk_en = 1'b1;
    end
    @(negedge clock) chk_en = 1'b0;

    check("trig_width_m1",      at(dut_fall_q, 0) - at(dut_rise_q, 0), 5);
    check("zera_before_trig",   at(dut_rise_q, 0) - at(dut_zera_q, 0), 1);
    check("pronto_delay_m1",    at(dut_pronto_q, 0) - at(dut_fall_q, 0), 33);
    check("timeout_noecho",     at(dut_tout_q, 0) - at(dut_fall_q, 1), 100);
    check("timeout_stuck",      at(dut_tout_q, 1) - at(dut_fall_q, 2), 100);
    check("pronto_delay_m4",    at(dut_pronto_q, 1) - at(dut_fall_q, 3), 33);
    check("boundary_pronto",    at(dut_pronto_q, 2) - at(dut_fall_q, 4), 101);
    check("trigger_pulses",     dut_rise_q.size(), n_meas);
    check("timeout_strobes",    dut_tout_q.size(), n_tout_model);
    check("pending_results",    exp_q.size(), 0);

    // abort during the third trigger cycle
    medir = 1'b0;
    @(negedge clock) medir = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (trigger) seen = 1'b1;
    end
    check("abort_trigger_seen", seen, 1);
    repeat (2) @(posedge clock);
    #2;
    check("trigger_before_reset", trigger, 1);
    reset = 1'b1;
    #1;
    check("abort_trigger", trigger, 0);  check("abort_zera", zera_cm, 0);
    check("abort_pronto", pronto, 0);    check("abort_timeout", timeout, 0);
    check("abort_pulso", pulso_cm, 0);   check("abort_medida", medida, 12'h000);
    check("abort_estado", db_estado, 0);
    medir = 1'b0;
    @(negedge clock) reset = 1'b0;
    strobes = 0;
    repeat (150) begin
      @(posedge clock); #1;
      if (pronto || timeout || trigger) strobes++;
    end
    check("post_abort_strobes", strobes, 0);
    check("post_abort_estado", db_estado, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
